// File: rtl/chest_pkg.sv
// rtl/chest_pkg.sv - shared constants, state encoding and helpers for chest_avg_stream
package chest_pkg;

  localparam int WIDTH_EST = 17;              // Q5.11 LS estimate / output part width
  localparam int N_EST     = 4;               // stored estimates averaged (power of two)
  localparam int N_SC      = 12;              // subcarrier beats per run
  localparam int ACC_W     = WIDTH_EST + 2;   // sum of N_EST estimates never overflows
  localparam int SHIFT     = $clog2(N_EST);

  localparam logic [1:0] LAST_ADDR = 2'(N_EST - 1);
  localparam logic [3:0] LAST_SC   = 4'(N_SC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CALC,
    ST_STREAM,
    ST_FIN
  } state_t;

  function automatic logic [ACC_W-1:0] sext_est(input logic [WIDTH_EST-1:0] v);
    return {{(ACC_W - WIDTH_EST){v[WIDTH_EST-1]}}, v};
  endfunction

endpackage

// File: rtl/chest_avg_div.sv
// rtl/chest_avg_div.sv - combinational divide of the estimate sum by N_EST
//
// Ports:
//   acc  in  ACC_W      signed sum of N_EST LS estimate parts
//   q    out WIDTH_EST  signed average
// Build option: CHEST_ROUND_EN selects round-half-up with clipping to the
// positive maximum; otherwise the result is truncated toward minus infinity.
module chest_avg_div
  import chest_pkg::*;
(
  input  logic [ACC_W-1:0]     acc,
  output logic [WIDTH_EST-1:0] q
);

`ifdef CHEST_ROUND_EN
  localparam logic [WIDTH_EST-1:0] Q_MAX = {1'b0, {(WIDTH_EST - 1){1'b1}}};

  logic [ACC_W:0]       sum;
  logic [ACC_W-SHIFT:0] rnd;
  logic                 unused_lsb;

  assign sum        = {acc[ACC_W-1], acc} + (ACC_W + 1)'(N_EST / 2);
  assign rnd        = sum[ACC_W:SHIFT];
  assign unused_lsb = ^sum[SHIFT-1:0];
  // Rounding up can only overflow on the positive side: sign clear but the
  // top result bit set means the value left the WIDTH_EST signed range.
  assign q = (!rnd[ACC_W-SHIFT] && rnd[WIDTH_EST-1]) ? Q_MAX : rnd[WIDTH_EST-1:0];
`else
  logic unused_lsb;

  // Dropping the low bits of a two's complement value is an arithmetic shift
  // that truncates toward minus infinity.
  assign unused_lsb = ^acc[SHIFT-1:0];
  assign q          = acc[ACC_W-1:SHIFT];
`endif

endmodule

// File: rtl/chest_avg_stream.sv
// rtl/chest_avg_stream.sv - averages the stored LS estimates and streams one per data subcarrier
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle run request, honoured only in IDLE
//   rd_addr         read address to the LS estimate store
//   est_r, est_i    addressed estimate, returned in the same cycle
//   h_r, h_i        averaged channel estimate
//   h_valid/h_ready beat handshake; sc_idx is the subcarrier of the beat
//   busy            state is not IDLE
//   done            one-cycle pulse after the last beat is accepted
// Build option: CHEST_ROUND_EN (rounding in chest_avg_div).
module chest_avg_stream
  import chest_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [1:0]           rd_addr,
  input  logic [WIDTH_EST-1:0] est_r,
  input  logic [WIDTH_EST-1:0] est_i,
  output logic [WIDTH_EST-1:0] h_r,
  output logic [WIDTH_EST-1:0] h_i,
  output logic                 h_valid,
  input  logic                 h_ready,
  output logic [3:0]           sc_idx,
  output logic                 busy,
  output logic                 done
);

  state_t               state, state_nxt;
  logic [ACC_W-1:0]     acc_r, acc_i;
  logic [WIDTH_EST-1:0] div_r, div_i;
  logic                 xfer;

  assign xfer = h_valid && h_ready;

  chest_avg_div u_div_r (.acc(acc_r), .q(div_r));
  chest_avg_div u_div_i (.acc(acc_i), .q(div_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_READ;
      ST_READ:   if (rd_addr == LAST_ADDR) state_nxt = ST_CALC;
      ST_CALC:   state_nxt = ST_STREAM;
      ST_STREAM: if (xfer && sc_idx == LAST_SC) state_nxt = ST_FIN;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    h_valid = (state == ST_STREAM);
    busy    = (state != ST_IDLE);
    done    = (state == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr <= '0;
      acc_r   <= '0;
      acc_i   <= '0;
      h_r     <= '0;
      h_i     <= '0;
      sc_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_addr <= '0;
            acc_r   <= '0;
            acc_i   <= '0;
          end
        end
        ST_READ: begin
          acc_r   <= acc_r + sext_est(est_r);
          acc_i   <= acc_i + sext_est(est_i);
          rd_addr <= rd_addr + 2'd1;  // wraps back to 0 after the last read
        end
        ST_CALC: begin
          h_r    <= div_r;
          h_i    <= div_i;
          sc_idx <= '0;
        end
        ST_STREAM: begin
          if (xfer) sc_idx <= (sc_idx == LAST_SC) ? 4'd0 : sc_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chest_avg_stream.sv
// tb/tb_chest_avg_stream.sv - scoreboard testbench for chest_avg_stream
module tb_chest_avg_stream;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [1:0]         rd_addr;
  logic signed [16:0] est_r, est_i;
  logic signed [16:0] h_r, h_i;
  logic               h_valid;
  logic               h_ready = 1'b1;
  logic [3:0]         sc_idx;
  logic               busy, done;

  typedef struct {
    int r;
    int i;
    int idx;
  } beat_t;

  beat_t exp_q[$];
  int    store_r[4];
  int    store_i[4];
  int    n_cmp = 0;
  int    n_err = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random

  assign est_r = store_r[rd_addr][16:0];
  assign est_i = store_i[rd_addr][16:0];

  chest_avg_stream dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr),
    .est_r(est_r), .est_i(est_i), .h_r(h_r), .h_i(h_i),
    .h_valid(h_valid), .h_ready(h_ready), .sc_idx(sc_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Reference average: exact floor of the mean (optionally rounded half up
  // and clipped to the 17-bit positive limit).
  function automatic int ref_avg(input int v[4]);
    int s, q;
    s = v[0] + v[1] + v[2] + v[3];
`ifdef CHEST_ROUND_EN
    s = s + 2;
`endif
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
`ifdef CHEST_ROUND_EN
    if (q > 65535) q = 65535;
`endif
    return q;
  endfunction

  // h_ready driver
  initial begin
    int k = 0;
    bit tog[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       h_ready = tog[k % 4];
        2:       h_ready = 1'($urandom_range(0, 1));
        default: h_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat and checks stalls hold.
  initial begin
    bit   stall_prev = 1'b0;
    int   prev_idx = 0, prev_r = 0, prev_i = 0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (stall_prev) begin
          chk("stall_valid", int'(h_valid), 1);
          chk("stall_idx", int'(sc_idx), prev_idx);
          chk("stall_hr", int'(h_r), prev_r);
          chk("stall_hi", int'(h_i), prev_i);
        end
        if (h_valid && h_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_hr", int'(h_r), e.r);
            chk("beat_hi", int'(h_i), e.i);
            chk("beat_idx", int'(sc_idx), e.idx);
          end
        end
        stall_prev = h_valid && !h_ready;
        prev_idx   = int'(sc_idx);
        prev_r     = int'(h_r);
        prev_i     = int'(h_i);
      end
    end
  end

  task automatic push_expected();
    beat_t b;
    b.r = ref_avg(store_r);
    b.i = ref_avg(store_i);
    for (int n = 0; n < 12; n++) begin
      b.idx = n;
      exp_q.push_back(b);
    end
  endtask

  // One full run. chk_lat checks done at T+18 (ready held high);
  // poke re-pulses start when beat 5 is on the bus.
  task automatic do_run(input bit chk_lat, input bit poke);
    int  cyc, d0;
    bit  poked = 1'b0;
    push_expected();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;       // edge T consumed start; now in T+1
    start = 1'b0;
    chk("busy_run", int'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      chk("rd_addr_seq", int'(rd_addr), k);
      @(posedge clk); #1;
    end
    cyc = 5;
    while (!done && cyc < 400) begin
      if (start) start = 1'b0;
      if (poke && !poked && h_valid && sc_idx == 4'd5) begin
        start = 1'b1;
        poked = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
    if (chk_lat) chk("done_latency", cyc, 18);
    @(posedge clk); #1;
    chk("busy_idle", int'(busy), 0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("beats_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int d0;
    for (int k = 0; k < 4; k++) begin
      store_r[k] = 0;
      store_i[k] = 0;
    end
    #2;
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_h_valid", int'(h_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_h_r", int'(h_r), 0);
    chk("rst_sc_idx", int'(sc_idx), 0);
    @(posedge clk); #3;
    rst = 1'b1;

    // Directed: mean 250 / -4, latency check
    store_r = '{100, 200, 300, 400};
    store_i = '{-4, -4, -4, -4};
    ready_mode = 0;
    do_run(1'b1, 1'b0);
    chk("dir_h_r_250", int'(h_r), 250);

    // Rounding boundary
    store_r = '{1, 1, 1, 0};
    store_i = '{-1, -1, -1, 0};
    do_run(1'b1, 1'b0);

    // Full-scale extremes
    store_r = '{65535, 65535, 65535, 65535};
    store_i = '{-65536, -65536, -65536, -65536};
    do_run(1'b1, 1'b0);
    chk("max_h_r", int'(h_r), 65535);
    chk("min_h_i", int'(h_i), -65536);

    // Back-pressure pattern
    store_r = '{-7, 13, 1000, -32768};
    store_i = '{5, 6, 7, 9};
    ready_mode = 1;
    do_run(1'b0, 1'b0);

    // start during STREAM ignored, then a fresh run
    ready_mode = 0;
    do_run(1'b1, 1'b1);
    store_r = '{3, -3, 17, 40000};
    do_run(1'b1, 1'b0);

    // Reset during READ at rd_addr=2
    push_expected();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_rd_addr", int'(rd_addr), 2);
    rst = 1'b0;
    #1;
    chk("abort_rd0", int'(rd_addr), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(h_valid), 0);
    chk("abort_h_r", int'(h_r), 0);
    chk("abort_h_i", int'(h_i), 0);
    chk("abort_done", int'(done), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (25) @(posedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    do_run(1'b1, 1'b0);

    // Random runs
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        store_r[k] = int'($urandom_range(0, 131071)) - 65536;
        store_i[k] = int'($urandom_range(0, 131071)) - 65536;
      end
      ready_mode = 2;
      do_run(1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chest_avg_stream.md
Name: chest_avg_stream

Overview:
- Downstream stage of the NRS least-squares complex multiplier in the channel-estimation chain.
- Reads the 4 stored LS estimates through the multiplier's 2-bit read port.
- Averages the 4 estimates into one complex channel estimate.
- Streams that estimate once per data subcarrier (12 per PRB) to the equalizer over a valid/ready handshake.

Parameters:
- WIDTH_EST, 17, signed width of each LS estimate part (Q5.11) and of each output part.
- N_EST, 4, number of stored LS estimates read and averaged; fixed power of two; log2 gives the shift.
- N_SC, 12, number of subcarrier beats streamed per run.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- rd_addr  out  2  read address driven to the LS estimate store.
- est_r  in  WIDTH_EST  real part of the addressed LS estimate, combinational same-cycle return.
- est_i  in  WIDTH_EST  imaginary part of the addressed LS estimate, combinational same-cycle return.
- h_r  out  WIDTH_EST  averaged channel estimate, real part.
- h_i  out  WIDTH_EST  averaged channel estimate, imaginary part.
- h_valid  out  1  h_r, h_i and sc_idx are valid.
- h_ready  in  1  consumer accepts the beat.
- sc_idx  out  4  subcarrier index of the current beat, 0..N_SC-1.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, rst=0) forces:
  - state=IDLE; rd_addr=0; both accumulators=0.
  - h_r=h_i=0; h_valid=0; sc_idx=0; busy=0; done=0.
  - Reset mid-run aborts the run; no done pulse is produced.
- FSM states: IDLE, READ, CALC, STREAM, FIN.
- IDLE:
  - start=1 moves to READ and clears both accumulators.
  - start is ignored in every other state (no queuing).
- READ, N_EST cycles:
  - rd_addr steps 0,1,2,3.
  - Each cycle adds sign-extended est_r and est_i into acc_r and acc_i (WIDTH_EST+2 = 19 bits each, cannot overflow).
  - After rd_addr=3 the FSM moves to CALC.
- CALC, 1 cycle:
  - h_r = acc_r >>> 2 and h_i = acc_i >>> 2, arithmetic shift, truncation toward minus infinity.
  - The result always fits WIDTH_EST; no saturation logic.
  - The next state is STREAM with h_valid=1 and sc_idx=0.
- STREAM:
  - A beat transfers when h_valid and h_ready are both 1.
  - h_r and h_i stay constant for the whole run.
  - sc_idx increments on each transfer and holds while h_ready=0; h_valid stays high while waiting.
  - A transfer with sc_idx=N_SC-1 drops h_valid and moves to FIN.
- FIN, 1 cycle: done=1, then IDLE. busy is 0 only in IDLE.
- Latency:
  - start accepted at cycle T.
  - READ occupies T+1..T+4.
  - CALC occupies T+5.
  - First h_valid at T+6.
  - With h_ready held at 1: last beat at T+17, done at T+18, back in IDLE at T+19.
- The upstream store must not be written during READ. The upstream controller guarantees this; this block does not check it.

Optional Feature:
- Macro CHEST_ROUND_EN.
- When defined, CALC computes (acc + 2) >>> 2 (round half up).
  - The addition uses a 20-bit intermediate.
  - The result is clipped to the 17-bit signed maximum if it exceeds it.
- When undefined, CALC uses plain truncation as specified above.

Decomposition:
- Shared package chest_pkg holds:
  - WIDTH_EST, N_EST, N_SC.
  - The FSM state encoding typedef.
  - An ACC_W constant (WIDTH_EST+2).
- One sub-module is natural: chest_avg_div, the combinational divide-by-4 with the optional rounding. It is instantiated twice, once for real and once for imaginary.

Test Plan:
- Store {100,200,300,400} real, {-4,-4,-4,-4} imag; start; h_ready=1 → rd_addr sequence 0..3, h_r=250, h_i=-4, 12 beats sc_idx 0..11, done at T+18.
- Store real {1,1,1,0}, imag {-1,-1,-1,0} → truncation gives h_r=0, h_i=-1; with CHEST_ROUND_EN gives h_r=1, h_i=-1.
- All estimates real=65535 (max 17-bit) and imag=-65536 → h_r=65535, h_i=-65536, no wrap; with CHEST_ROUND_EN h_r clips to 65535.
- h_ready toggles 1,0,0,1,… → h_valid stays high, sc_idx and h_r/h_i hold during stalls, exactly 12 transfers, single done pulse.
- start pulsed again during STREAM at sc_idx=5 → ignored; run completes with 12 beats; a new start after done re-runs from rd_addr=0.
- rst driven low during READ at rd_addr=2 → all outputs return to 0 immediately, no done; after release a start produces a correct full run.
